// File: rtl/reg_transfer_pkg.sv
// Shared encodings and default sizes for the register-transfer sequencer.
package reg_transfer_pkg;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_NUM_REGS = 4;
    localparam int SEL_W        = 2;

    typedef enum logic [1:0] {
        OP_LOAD_IMM = 2'd0,
        OP_MOVE     = 2'd1,
        OP_INC      = 2'd2,
        OP_SWAP     = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WRITE2 = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/reg_transfer_sequencer.sv
// Command-driven fetch/write/done sequencer driving a bank of load-enable registers
// through a shared D bus; every output is a register decoded from the next state.
module reg_transfer_sequencer
    import reg_transfer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [SEL_W-1:0]          cmd_src,
    input  logic [SEL_W-1:0]          cmd_dst,
    input  logic [WIDTH-1:0]          cmd_imm,
    input  logic [NUM_REGS*WIDTH-1:0] Q_bus,
    output logic [WIDTH-1:0]          D,
    output logic [NUM_REGS-1:0]       Load,
    output logic                      busy,
    output logic                      done
);

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = {NUM_REGS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Carry out of the top bit is dropped, so the maximum value wraps to zero.
    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
        return v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e               state_r, next_state_s;
    op_e                  op_r, op_s;
    logic [SEL_W-1:0]     src_r, src_s, dst_r, dst_s;
    logic [WIDTH-1:0]     imm_r, imm_s;
    logic [WIDTH-1:0]     tmp_a_r, tmp_a_s, tmp_b_r, tmp_b_s;
    logic [WIDTH-1:0]     q_arr_s [NUM_REGS];
    logic [WIDTH-1:0]     d_s;
    logic [NUM_REGS-1:0]  load_s;

    // Unpack the register outputs into an indexable array.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            q_arr_s[i] = Q_bus[i*WIDTH +: WIDTH];
        end
    end

    // Next-state, command latch and temporary capture.
    always_comb begin
        next_state_s = state_r;
        op_s         = op_r;
        src_s        = src_r;
        dst_s        = dst_r;
        imm_s        = imm_r;
        tmp_a_s      = tmp_a_r;
        tmp_b_s      = tmp_b_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_s         = op_e'(cmd_op);
                    src_s        = cmd_src;
                    dst_s        = cmd_dst;
                    imm_s        = cmd_imm;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                tmp_a_s      = q_arr_s[src_r];
                tmp_b_s      = q_arr_s[dst_r];
                next_state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (op_r == OP_SWAP) begin
                    next_state_s = ST_WRITE2;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_WRITE2: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Decode the bus drive for the state being entered so D/Load can be registered.
    always_comb begin
        d_s    = {WIDTH{1'b0}};
        load_s = {NUM_REGS{1'b0}};
        case (next_state_s)
            ST_WRITE: begin
                load_s = sel_onehot(dst_s);
                case (op_s)
                    OP_LOAD_IMM: d_s = imm_s;
                    OP_INC:      d_s = wrap_inc(tmp_a_s);
                    OP_MOVE:     d_s = tmp_a_s;
                    OP_SWAP:     d_s = tmp_a_s;
                    default:     d_s = {WIDTH{1'b0}};
                endcase
            end
            ST_WRITE2: begin
                load_s = sel_onehot(src_s);
                d_s    = tmp_b_s;
            end
            default: begin
                d_s    = {WIDTH{1'b0}};
                load_s = {NUM_REGS{1'b0}};
            end
        endcase
    end

    // State, latched command, temporaries and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_LOAD_IMM;
            src_r     <= {SEL_W{1'b0}};
            dst_r     <= {SEL_W{1'b0}};
            imm_r     <= {WIDTH{1'b0}};
            tmp_a_r   <= {WIDTH{1'b0}};
            tmp_b_r   <= {WIDTH{1'b0}};
            D         <= {WIDTH{1'b0}};
            Load      <= {NUM_REGS{1'b0}};
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_r   <= next_state_s;
            op_r      <= op_s;
            src_r     <= src_s;
            dst_r     <= dst_s;
            imm_r     <= imm_s;
            tmp_a_r   <= tmp_a_s;
            tmp_b_r   <= tmp_b_s;
            D         <= d_s;
            Load      <= load_s;
            done      <= (next_state_s == ST_DONE);
            busy      <= (next_state_s != ST_IDLE);
            cmd_ready <= (next_state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Bench for reg_transfer_sequencer: a behavioural register bank is driven by the
// DUT's D/Load and compared against a command-level model of the register file.
module tb_reg_transfer_sequencer;
    import reg_transfer_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic [2:0] cmd_imm;
    logic [11:0] Q_bus;
    logic [2:0] D;
    logic [3:0] Load;
    logic       busy;
    logic       done;

    logic [2:0] bank  [4];
    logic [2:0] mregs [4];
    bit         mknown[4];
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    reg_transfer_sequencer #(.WIDTH(3), .NUM_REGS(4)) dut (
        .CLK(CLK), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .Q_bus(Q_bus), .D(D), .Load(Load), .busy(busy), .done(done)
    );

    // External three-bit load-enable registers sharing D and CLK
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (Load[i]) bank[i] <= D;
        end
    end
    assign Q_bus = {bank[3], bank[2], bank[1], bank[0]};

    // Issue one command from an IDLE negedge and follow it to the next IDLE negedge.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src,
                           input logic [1:0] dst, input logic [2:0] imm);
        logic [2:0] a, b, w1;
        logic [3:0] l1, l2;
        a  = mregs[src];
        b  = mregs[dst];
        l1 = 4'b0001 << dst;
        l2 = 4'b0001 << src;
        case (op)
            2'd0:    w1 = imm;
            2'd2:    w1 = 3'((int'(a) + 1) % 8);
            default: w1 = a;
        endcase
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_src = 2'($urandom); cmd_dst = 2'($urandom);
        cmd_imm = 3'($urandom);
        checks++;
        if ({Load, D, done, busy, cmd_ready} !== {4'b0000, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_outputs: got Load=%b D=%b done=%b busy=%b ready=%b want 0000/000/0/1/0",
                     Load, D, done, busy, cmd_ready);
        end
        @(negedge CLK);
        checks++;
        if (Load !== l1 || D !== w1 || done !== 1'b0) begin
            errors++;
            $display("FAIL write1 op=%0d: got Load=%b D=%b done=%b want Load=%b D=%b done=0",
                     op, Load, D, done, l1, w1);
        end
        if (op == 2'd3) begin
            @(negedge CLK);
            checks++;
            if (Load !== l2 || D !== b || done !== 1'b0) begin
                errors++;
                $display("FAIL write2: got Load=%b D=%b done=%b want Load=%b D=%b done=0",
                         Load, D, done, l2, b);
            end
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || Load !== 4'b0000 || D !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle: got done=%b Load=%b D=%b busy=%b want 1/0000/000/1",
                     done, Load, D, busy);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || Load !== 4'b0000) begin
            errors++;
            $display("FAIL back_to_idle: got done=%b ready=%b busy=%b Load=%b want 0/1/0/0000",
                     done, cmd_ready, busy, Load);
        end
        mregs[dst]  = w1;
        mknown[dst] = 1'b1;
        if (op == 2'd3) mregs[src] = b;
        for (int i = 0; i < 4; i++) begin
            if (mknown[i]) begin
                checks++;
                if (bank[i] !== mregs[i]) begin
                    errors++;
                    $display("FAIL bank%0d after op=%0d: got %b want %b", i, op, bank[i], mregs[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_src = 2'd0; cmd_dst = 2'd0; cmd_imm = 3'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({Load, D, done, busy, cmd_ready} !== {4'b0000, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got Load=%b D=%b done=%b busy=%b ready=%b want 0000/000/0/0/1",
                     Load, D, done, busy, cmd_ready);
        end
        Reset = 1'b0;
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_directed();
        run_cmd(2'd0, 2'd3, 2'd2, 3'b101);
        checks++;
        if (bank[2] !== 3'b101) begin
            errors++; $display("FAIL load_imm_reg2: got %b want 101", bank[2]);
        end
        run_cmd(2'd1, 2'd2, 2'd0, 3'b000);
        checks++;
        if (bank[0] !== 3'b101 || bank[2] !== 3'b101) begin
            errors++; $display("FAIL move_2_to_0: got r0=%b r2=%b want 101/101", bank[0], bank[2]);
        end
        run_cmd(2'd0, 2'd0, 2'd1, 3'b111);
        run_cmd(2'd2, 2'd1, 2'd1, 3'b000);
        checks++;
        if (bank[1] !== 3'b000) begin
            errors++; $display("FAIL inc_wrap_reg1: got %b want 000", bank[1]);
        end
        run_cmd(2'd0, 2'd0, 2'd0, 3'b010);
        run_cmd(2'd0, 2'd0, 2'd3, 3'b110);
        run_cmd(2'd3, 2'd0, 2'd3, 3'b000);
        checks++;
        if (bank[0] !== 3'b110 || bank[3] !== 3'b010) begin
            errors++; $display("FAIL swap_0_3: got r0=%b r3=%b want 110/010", bank[0], bank[3]);
        end
    endtask

    task automatic test_handshake();
        logic [2:0] base;
        base = mregs[2];
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_src = 2'd2; cmd_dst = 2'd2; cmd_imm = 3'd0;
        for (int n = 0; n < 12; n++) begin
            checks++;
            if (cmd_ready !== (n % 4 == 0)) begin
                errors++; $display("FAIL hold_valid_ready n=%0d: got %b want %b", n, cmd_ready, (n % 4 == 0));
            end
            if (n % 4 == 2) begin
                checks++;
                if (Load !== 4'b0100 || D !== 3'((int'(base) + n / 4 + 1) % 8)) begin
                    errors++;
                    $display("FAIL hold_valid_write n=%0d: got Load=%b D=%b want 0100/%b",
                             n, Load, D, 3'((int'(base) + n / 4 + 1) % 8));
                end
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        mregs[2] = 3'((int'(base) + 3) % 8);
        checks++;
        if (bank[2] !== mregs[2] || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL hold_valid_result: got r2=%b ready=%b want %b/1", bank[2], cmd_ready, mregs[2]);
        end
    endtask

    task automatic test_reset_mid_swap();
        run_cmd(2'd0, 2'd0, 2'd0, 3'b011);
        run_cmd(2'd0, 2'd0, 2'd1, 3'b100);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_imm = 3'd0;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (Load !== 4'b0010 || D !== 3'b011) begin
            errors++; $display("FAIL rst_swap_write1: got Load=%b D=%b want 0010/011", Load, D);
        end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if ({Load, D, done, busy, cmd_ready} !== {4'b0000, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_swap_state: got Load=%b D=%b done=%b busy=%b ready=%b want 0000/000/0/0/1",
                     Load, D, done, busy, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0 || Load !== 4'b0000) begin
                errors++; $display("FAIL rst_swap_quiet%0d: got done=%b Load=%b want 0/0000", i, done, Load);
            end
        end
        mregs[1] = 3'b011;
        checks++;
        if (bank[1] !== 3'b011 || bank[0] !== 3'b011) begin
            errors++; $display("FAIL rst_swap_regs: got r1=%b r0=%b want 011/011", bank[1], bank[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mknown[i] = 1'b0;
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid_swap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
